// File: rtl/qe_pkg.sv
// Shared types and constants for the quadratic-equation / product-sum MAC feeder.
package qe_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;

  localparam logic MODE_QE = 1'b0;
  localparam logic MODE_PS = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    HOLD
  } feeder_state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] x;
  } operand_pair_t;

endpackage

// File: rtl/qe_operand_feeder_if.sv
// Feeder-to-MAC operand/result bus; master is the feeder, slave is the MAC.
interface qe_operand_feeder_if;
  import qe_pkg::*;

  logic [OP_W-1:0]  mac_a;
  logic [OP_W-1:0]  mac_b;
  logic [OP_W-1:0]  mac_c;
  logic [OP_W-1:0]  mac_x;
  logic             mac_mode;
  logic             mac_valid_in;
  logic             mac_last_input;
  logic             mac_valid_out;
  logic [RES_W-1:0] mac_result;

  modport master (
    output mac_a, mac_b, mac_c, mac_x, mac_mode, mac_valid_in, mac_last_input,
    input  mac_valid_out, mac_result
  );

  modport slave (
    input  mac_a, mac_b, mac_c, mac_x, mac_mode, mac_valid_in, mac_last_input,
    output mac_valid_out, mac_result
  );

endinterface

// File: rtl/qe_operand_fifo.sv
// Show-ahead operand-pair FIFO; full is judged before any same-cycle pop.
module qe_operand_fifo
  import qe_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  operand_pair_t           push_data,
  input  logic                    pop,
  output operand_pair_t           pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  operand_pair_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qe_operand_feeder.sv
// Buffers host operand pairs, bursts them into the MAC and returns its result.
// Define QE_FEEDER_TIMEOUT_EN to abort a job that waits TIMEOUT cycles for a result.
module qe_operand_feeder
  import qe_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [OP_W-1:0]      wr_a,
  input  logic [OP_W-1:0]      wr_x,
  output logic                 wr_full,
  input  logic [OP_W-1:0]      cfg_b,
  input  logic [OP_W-1:0]      cfg_c,
  input  logic                 start,
  input  logic                 start_mode,
  output logic                 busy,
  qe_operand_feeder_if.master  mac,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     res_data,
  output logic                 res_timeout
);

  localparam int unsigned BEAT_W = $clog2(DEPTH) + 1;

  feeder_state_e     state;
  logic [BEAT_W-1:0] n_beats;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] fifo_count;
  operand_pair_t     head;
  logic              fifo_empty;
  logic              start_ok_c;
  logic              more_c;
  logic              pop_c;

`ifdef QE_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;
  logic [TO_W-1:0] to_cnt;
`else
  // TIMEOUT has no effect while the abort path is compiled out.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // First beat is popped in the start cycle so it appears one cycle later.
  assign start_ok_c = (state == IDLE) && start && !fifo_empty;
  assign more_c     = (state == STREAM) && (beat_cnt != n_beats);
  assign pop_c      = start_ok_c || more_c;

  qe_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data ('{a: wr_a, x: wr_x}),
    .pop       (pop_c),
    .pop_data  (head),
    .full      (wr_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      n_beats            <= '0;
      beat_cnt           <= '0;
      busy               <= 1'b0;
      mac.mac_a          <= '0;
      mac.mac_b          <= '0;
      mac.mac_c          <= '0;
      mac.mac_x          <= '0;
      mac.mac_mode       <= 1'b0;
      mac.mac_valid_in   <= 1'b0;
      mac.mac_last_input <= 1'b0;
      res_valid          <= 1'b0;
      res_data           <= '0;
      res_timeout        <= 1'b0;
`ifdef QE_FEEDER_TIMEOUT_EN
      to_cnt             <= '0;
`endif
    end else begin
      // Operand bus idles at zero unless a beat is launched this cycle.
      mac.mac_a          <= '0;
      mac.mac_b          <= '0;
      mac.mac_c          <= '0;
      mac.mac_x          <= '0;
      mac.mac_valid_in   <= 1'b0;
      mac.mac_last_input <= 1'b0;

      case (state)
        IDLE: begin
          if (start_ok_c) begin
            state              <= STREAM;
            busy               <= 1'b1;
            mac.mac_mode       <= start_mode;
            n_beats            <= (start_mode == MODE_QE) ? BEAT_W'(1) : fifo_count;
            beat_cnt           <= BEAT_W'(1);
            mac.mac_valid_in   <= 1'b1;
            mac.mac_a          <= head.a;
            mac.mac_x          <= head.x;
            mac.mac_b          <= (start_mode == MODE_QE) ? cfg_b : '0;
            mac.mac_c          <= (start_mode == MODE_QE) ? cfg_c : '0;
            mac.mac_last_input <= (start_mode == MODE_PS) && (fifo_count == BEAT_W'(1));
          end
        end

        STREAM: begin
          if (more_c) begin
            beat_cnt           <= beat_cnt + BEAT_W'(1);
            mac.mac_valid_in   <= 1'b1;
            mac.mac_a          <= head.a;
            mac.mac_x          <= head.x;
            mac.mac_last_input <= (mac.mac_mode == MODE_PS) &&
                                  ((beat_cnt + BEAT_W'(1)) == n_beats);
          end else begin
            state <= WAIT;
`ifdef QE_FEEDER_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end

        WAIT: begin
          if (mac.mac_valid_out) begin
            state       <= HOLD;
            res_valid   <= 1'b1;
            res_data    <= mac.mac_result;
            res_timeout <= 1'b0;
          end
`ifdef QE_FEEDER_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state       <= HOLD;
            res_valid   <= 1'b1;
            res_data    <= '0;
            res_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        HOLD: begin
          if (res_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            mac.mac_mode <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/qe_operand_feeder.md
Name: qe_operand_feeder

Overview:
- Transmit-side driver for the quadratic-equation / product-sum MAC.
- Buffers host-written operand pairs and streams them to the MAC's in_a/in_b/in_c/in_x, valid_in, last_input and mode inputs.
- Waits for the MAC's valid_out, captures its 16-bit result and returns it to the host over a valid/ready handshake.
- Owns job sequencing so the MAC sees well-formed bursts.

Parameters:
- DEPTH, 8, operand-pair buffer entries (power of 2, at least 2).
- TIMEOUT, 64, cycles allowed in WAIT for mac_valid_out before the job aborts.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- wr_en  input  1  push {wr_a, wr_x} into the buffer.
- wr_a  input  8  operand a / a_i.
- wr_x  input  8  operand x / x_i.
- wr_full  output  1  buffer full; a write while full is dropped.
- cfg_b  input  8  mode-0 coefficient b, sampled at start.
- cfg_c  input  8  mode-0 coefficient c, sampled at start.
- start  input  1  single-cycle job request.
- start_mode  input  1  0 = quadratic (a*x^2+b*x+c), 1 = product-sum.
- busy  output  1  high in any state other than IDLE.
- mac_a, mac_b, mac_c, mac_x  output  8 each  operand drive to the MAC.
- mac_mode  output  1  mode drive to the MAC.
- mac_valid_in  output  1  operand beat valid.
- mac_last_input  output  1  final beat of a mode-1 burst.
- mac_valid_out  input  1  MAC result strobe.
- mac_result  input  16  MAC result.
- res_valid  output  1  result available to host.
- res_ready  input  1  host accepts the result.
- res_data  output  16  captured result.
- res_timeout  output  1  result is a timeout abort; qualified by res_valid.

Behaviour:
- Reset value of every output is 0. Buffer empty, state IDLE, counters 0. Async assert; deassert takes effect on the next edge.
- All mac_* and res_* outputs are registered.
- mac_a/b/c/x are driven 0 whenever mac_valid_in = 0.
- FSM states: IDLE, STREAM, WAIT, HOLD.
- IDLE:
  - start=1 with buffer non-empty: latch start_mode, cfg_b, cfg_c; snapshot beat count N; go STREAM.
  - Mode 0: N = 1.
  - Mode 1: N = occupancy at the start cycle.
  - start with buffer empty is ignored. start outside IDLE is ignored.
- STREAM:
  - One buffer pop per cycle, N consecutive cycles of mac_valid_in=1. No bubbles.
  - First beat appears the cycle after start (latency 1).
  - mac_mode is held at the latched mode for the whole job, through HOLD.
  - Mode 0: mac_b/mac_c = latched cfg_b/cfg_c.
  - Mode 1: mac_b = mac_c = 0; mac_last_input=1 on beat N only.
  - Mode 0 never asserts mac_last_input.
  - After beat N, go WAIT.
- WAIT:
  - Cycle counter increments each cycle.
  - mac_valid_out=1: capture mac_result into res_data, res_timeout=0, go HOLD.
  - Counter reaches TIMEOUT-1 with no strobe: res_data=0, res_timeout=1, go HOLD.
  - mac_valid_out in the same cycle as the timeout: the result wins.
- mac_valid_out outside WAIT is ignored.
- HOLD:
  - res_valid=1; res_data and res_timeout held stable until res_ready=1.
  - On handshake: res_valid drops next cycle, go IDLE.
  - A new start is accepted the cycle after the return to IDLE.
- Buffer writes:
  - Accepted in any state when not full.
  - Writes during STREAM land behind the snapshot and are not part of the current job.
  - wr_full is computed before the same-cycle pop: a write while full is dropped even if a pop occurs in that cycle.
- Reset mid-job: the burst is abandoned immediately, buffer contents are discarded, and outputs return to 0.
- Data widths: buffer entry is 16 bits {a,x}. No arithmetic in this block beyond the counters.
- Beat counter width: clog2(DEPTH)+1. Timeout counter width: clog2(TIMEOUT)+1.

Optional Feature:
- Macro QE_FEEDER_TIMEOUT_EN.
- Defined: WAIT timeout is active as described above.
- Undefined: WAIT waits indefinitely for mac_valid_out, res_timeout is tied to 0, and the timeout counter is not built.

Decomposition:
- Package qe_pkg:
  - OP_W=8, RES_W=16.
  - MODE_QE=1'b0, MODE_PS=1'b1.
  - Feeder state enum {IDLE, STREAM, WAIT, HOLD}.
- Sub-module qe_operand_fifo:
  - Synchronous FIFO, DEPTH x 16.
  - Ports: push/pop, full, empty, occupancy count.
  - Read data valid in the same cycle (show-ahead).

Test Plan:
- Mode 0: write a=2,x=3; cfg_b=4, cfg_c=5; start. Expect one beat with mac_a=2, mac_x=3, mac_b=4, mac_c=5, mac_mode=0, last=0. MAC model returns 35 → res_valid, res_data=35, res_timeout=0.
- Mode 1: write (1,2),(3,4),(5,6); start. Expect 3 back-to-back beats, mac_last_input only on (5,6). MAC returns 44 → res_data=44. busy is high from start+1 until the handshake.
- Backpressure: hold res_ready=0 for 10 cycles. Expect res_data stable and start pulses ignored. Raise res_ready → IDLE next cycle.
- Timeout (macro on, TIMEOUT=64): MAC never strobes → res_valid with res_timeout=1, res_data=0, 64 cycles after the last beat.
- Full/snapshot: fill 8 entries; a 9th write is dropped and wr_full=1. Start mode 1 and write 2 more during STREAM → exactly 8 beats, 2 entries remain.
- Reset on beat 2 of a 4-beat burst → all outputs 0 next cycle, buffer empty, a subsequent start is ignored.
